// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Owns the program counter and sequences instruction fetch. A FETCH/WAIT/ISSUE
//   state machine issues requests to instruction memory, captures the returned
//   word, and holds it for decode until it is consumed. On consume, the next PC
//   comes from jr > jmp > br_taken > sequential.
//
//   Handshake: imem_req stays high with a constant imem_addr until imem_ack is
//   seen. imem_ack is ignored whenever imem_req is low. An instruction is
//   consumed in a cycle with instr_valid=1, dec_ready=1 and stall=0. Redirect
//   inputs are sampled only in that cycle.
//
//   Optional build macro: PC_FETCH_DELAY_SLOT_EN enables MIPS delay-slot
//   semantics. A redirect is held as a pending target and applied after the
//   next (slot) instruction is consumed.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   imem_req/addr       fetch request and address (address = pc)
//   imem_ack/rdata      memory response
//   instr_valid/instr/instr_pc  instruction presented to decode
//   dec_ready, stall    consume control
//   br_taken/br_imm16, jmp/jmp_idx, jr/jr_target   redirect sources
//   addr_err            pulse in the consume cycle of a misaligned jr
//   pc                  current PC register
//   state_dbg           FSM state (0=FETCH, 1=WAIT, 2=ISSUE)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] EXC_VEC  = 32'h00400004
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_imm16,
  input  logic        jmp,
  input  logic [25:0] jmp_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        addr_err,
  output logic [31:0] pc,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state;
  logic        consume;
  logic        jr_misaligned;
  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] redir_pc;
  logic [31:0] next_pc;

  always_comb begin
    consume       = (state == S_ISSUE) && dec_ready && !stall;
    seq_pc        = instr_pc + 32'd4;
    // Word offset: sign-extend the 16-bit immediate and scale by 4.
    br_off        = {{14{br_imm16[15]}}, br_imm16, 2'b00};
    jr_misaligned = jr && (jr_target[1:0] != 2'b00);
    redir_pc      = seq_pc;
    if (jr)            redir_pc = jr_misaligned ? EXC_VEC : jr_target;
    else if (jmp)      redir_pc = {seq_pc[31:28], jmp_idx, 2'b00};
    else if (br_taken) redir_pc = seq_pc + br_off;
  end

  // Request is a function of state, gated by reset so it drops the moment
  // reset asserts and returns on the first cycle after release.
  assign imem_req  = !rst && (state != S_ISSUE);
  assign imem_addr = pc;
  assign state_dbg = state;

`ifdef PC_FETCH_DELAY_SLOT_EN
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        redir;

  always_comb begin
    redir    = jr || jmp || br_taken;
    // Slot instruction: apply the stored target; its own redirects are ignored.
    next_pc  = pend_valid ? pend_pc : seq_pc;
    addr_err = consume && !pend_valid && jr_misaligned;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
    end else if (consume) begin
      if (pend_valid) begin
        pend_valid <= 1'b0;
      end else if (redir) begin
        pend_valid <= 1'b1;
        pend_pc    <= redir_pc;
      end
    end
  end
`else
  always_comb begin
    next_pc  = redir_pc;
    addr_err = consume && jr_misaligned;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
    end else begin
      case (state)
        S_FETCH, S_WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= S_ISSUE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_ISSUE: begin
          if (consume) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl: directed scenarios plus randomized fetch/consume
// traffic checked against a PC model computed from the redirect rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h00400000;
  localparam logic [31:0] EXC_VEC  = 32'h00400004;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_imm16;
  logic        jmp;
  logic [25:0] jmp_idx;
  logic        jr;
  logic [31:0] jr_target;
  logic        addr_err;
  logic [31:0] pc;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic [31:0] m_pend;
  logic        m_pend_v;
  logic [31:0] exp_q[$];

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready), .stall(stall),
    .br_taken(br_taken), .br_imm16(br_imm16),
    .jmp(jmp), .jmp_idx(jmp_idx),
    .jr(jr), .jr_target(jr_target),
    .addr_err(addr_err), .pc(pc), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = 32'd0; dec_ready = 1'b0; stall = 1'b0;
    br_taken = 1'b0; br_imm16 = 16'd0; jmp = 1'b0; jmp_idx = 26'd0;
    jr = 1'b0; jr_target = 32'd0;
  endtask

  // Fetch one instruction with ack held off for 'delay' cycles. Entry: DUT requesting.
  task automatic fetch_one(input int delay);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_req: req=%0b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, m_pc);
    end
    for (int i = 0; i < delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait: req=%0b addr=%h valid=%0b, expected req=1 addr=%h valid=0",
                 imem_req, imem_addr, instr_valid, m_pc);
      end
    end
    imem_ack = 1'b1;
    imem_rdata = $urandom;
    exp_q.push_back(imem_rdata);
    @(negedge clk);
    imem_ack = 1'b0;
    m_instr = exp_q.pop_front();
    m_ipc = m_pc;
    checks++;
    if (instr_valid !== 1'b1 || instr !== m_instr || instr_pc !== m_ipc || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_capture: valid=%0b instr=%h ipc=%h req=%0b, expected 1 %h %h 0",
               instr_valid, instr, instr_pc, imem_req, m_instr, m_ipc);
    end
  endtask

  // Consume the held instruction after 'nstall' blocked cycles. Entry: DUT in ISSUE.
  task automatic consume_one(input logic br, input logic [15:0] imm, input logic j,
                             input logic [25:0] idx, input logic jrr, input logic [31:0] tgt,
                             input int nstall);
    logic [31:0] seq, tgt_m, nxt;
    logic err;
    for (int i = 0; i < nstall; i++) begin
      stall = 1'b1; dec_ready = 1'($urandom_range(0, 1));
      br_taken = 1'($urandom_range(0, 1)); jmp = 1'($urandom_range(0, 1));
      jr = 1'($urandom_range(0, 1)); jr_target = $urandom;
      imem_ack = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== m_instr || instr_pc !== m_ipc ||
          imem_req !== 1'b0 || pc !== m_pc || addr_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%0b instr=%h ipc=%h req=%0b pc=%h err=%0b, expected 1 %h %h 0 %h 0",
                 instr_valid, instr, instr_pc, imem_req, pc, addr_err, m_instr, m_ipc, m_pc);
      end
    end
    clear_inputs();
    dec_ready = 1'b1; br_taken = br; br_imm16 = imm; jmp = j; jmp_idx = idx;
    jr = jrr; jr_target = tgt;

    // Model: target from the redirect rules, plain arithmetic.
    seq = m_ipc + 32'd4;
    err = 1'b0;
    tgt_m = seq;
    if (jrr) begin
      err = (tgt % 32'd4) != 32'd0;
      tgt_m = err ? EXC_VEC : tgt;
    end else if (j) begin
      tgt_m = (seq & 32'hF000_0000) | (32'(idx) * 32'd4);
    end else if (br) begin
      tgt_m = seq + 32'(int'($signed(imm)) * 4);
    end
`ifdef PC_FETCH_DELAY_SLOT_EN
    if (m_pend_v) begin
      nxt = m_pend; m_pend_v = 1'b0; err = 1'b0;
    end else if (br || j || jrr) begin
      m_pend = tgt_m; m_pend_v = 1'b1; nxt = seq;
    end else begin
      nxt = seq;
    end
`else
    nxt = tgt_m;
`endif
    #1;
    checks++;
    if (addr_err !== err) begin
      errors++;
      $display("FAIL addr_err: got %0b, expected %0b (ipc=%h tgt=%h)", addr_err, err, m_ipc, tgt);
    end
    @(negedge clk);
    clear_inputs();
    m_pc = nxt;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || instr_valid !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL next_pc: req=%0b addr=%h pc=%h valid=%0b err=%0b, expected 1 %h %h 0 0",
               imem_req, imem_addr, pc, instr_valid, addr_err, m_pc, m_pc);
    end
  endtask

  // Steer the DUT so the next fetch is at 'addr'.
  task automatic goto_pc(input logic [31:0] addr);
    fetch_one(0);
    consume_one(1'b0, 16'd0, 1'b0, 26'd0, 1'b1, addr, 0);
`ifdef PC_FETCH_DELAY_SLOT_EN
    fetch_one(0);
    consume_one(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 0);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || pc !== RESET_PC || instr_valid !== 1'b0 || instr !== 32'd0 ||
        instr_pc !== 32'd0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: req=%0b pc=%h valid=%0b instr=%h ipc=%h err=%0b",
               imem_req, pc, instr_valid, instr, instr_pc, addr_err);
    end
    rst = 1'b0;
    imem_ack = 1'b0;
    m_pc = RESET_PC; m_pend_v = 1'b0; m_pend = 32'd0;
    #1;
  endtask

  task automatic test_throughput();
    dec_ready = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
        errors++;
        $display("FAIL tput_addr: req=%0b addr=%h, expected 1 %h", imem_req, imem_addr, m_pc);
      end
      imem_rdata = $urandom;
      exp_q.push_back(imem_rdata);
      @(negedge clk);
      m_instr = exp_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== m_pc || instr !== m_instr || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL tput_issue: valid=%0b ipc=%h instr=%h req=%0b, expected 1 %h %h 0",
                 instr_valid, instr_pc, instr, imem_req, m_pc, m_instr);
      end
      @(negedge clk);
      m_pc = m_pc + 32'd4;
    end
    clear_inputs();
  endtask

  task automatic test_wait();
    fetch_one(3);
    consume_one(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 0);
  endtask

  task automatic test_branch();
    goto_pc(32'h00400010);
    fetch_one(1);
    consume_one(1'b1, 16'hFFFC, 1'b0, 26'd0, 1'b0, 32'd0, 0);
    goto_pc(32'h00400010);
    fetch_one(0);
    consume_one(1'b1, 16'h0003, 1'b0, 26'd0, 1'b0, 32'd0, 0);
  endtask

  task automatic test_jump_priority();
    goto_pc(32'h00400000);
    fetch_one(0);
    consume_one(1'b1, 16'h1234, 1'b1, 26'h0100010, 1'b0, 32'd0, 0);
    fetch_one(0);
    consume_one(1'b1, 16'h0001, 1'b1, 26'h0000001, 1'b1, 32'h00400102, 0);
  endtask

  task automatic test_stall_wrap();
    goto_pc(32'hFFFFFFFC);
    fetch_one(2);
    consume_one(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 5);
  endtask

  task automatic test_reset_mid_wait();
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || pc !== RESET_PC || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait: req=%0b pc=%h valid=%0b, expected 0 %h 0", imem_req, pc, instr_valid, RESET_PC);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pc = RESET_PC; m_pend_v = 1'b0;
    #1;
    fetch_one(0);
    consume_one(1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1);
  endtask

`ifdef PC_FETCH_DELAY_SLOT_EN
  task automatic test_delay_slot();
    goto_pc(32'h00400010);
    fetch_one(0);
    consume_one(1'b1, 16'h000B, 1'b0, 26'd0, 1'b0, 32'd0, 0);
    checks++;
    if (imem_addr !== 32'h00400014) begin
      errors++;
      $display("FAIL ds_slot_addr: got %h, expected 00400014", imem_addr);
    end
    fetch_one(0);
    consume_one(1'b1, 16'h0100, 1'b1, 26'h0000003, 1'b0, 32'd0, 0);
    checks++;
    if (imem_addr !== 32'h00400040) begin
      errors++;
      $display("FAIL ds_target_addr: got %h, expected 00400040", imem_addr);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      fetch_one($urandom_range(0, 3));
      consume_one(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
                  26'($urandom), 1'($urandom_range(0, 3) == 0), t, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_wait();
    test_branch();
    test_jump_priority();
    test_stall_wrap();
    test_reset_mid_wait();
`ifdef PC_FETCH_DELAY_SLOT_EN
    test_delay_slot();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Owns the program counter and sequences instruction fetch for the CPU core. Runs a request/acknowledge handshake with instruction memory and presents each fetched word to decode. Computes the next PC from one of four sources: sequential, branch (18-bit sign-extended word offset), jump (26-bit index) or register jump. It internally performs the same 18-bit sign extension the branch datapath uses, so the branch target is formed inside this block.

Parameters:
RESET_PC, 32'h00400000, PC value loaded on reset.
EXC_VEC, 32'h00400004, PC loaded when a register-jump target is misaligned.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; equals pc.
imem_ack  in  1  memory has returned data this cycle; ignored unless imem_req=1.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
instr_valid  out  1  instr/instr_pc hold an unconsumed instruction.
instr  out  32  fetched instruction.
instr_pc  out  32  address of instr.
dec_ready  in  1  decode consumes instr this cycle.
stall  in  1  pipeline hold; blocks consumption.
br_taken  in  1  branch taken; sampled in consume cycle only.
br_imm16  in  16  branch immediate.
jmp  in  1  j/jal; sampled in consume cycle only.
jmp_idx  in  26  jump index.
jr  in  1  jr/jalr; sampled in consume cycle only.
jr_target  in  32  register jump target.
addr_err  out  1  one-cycle pulse on misaligned jr target.
pc  out  32  current PC register.

Behaviour:
- Reset values: pc=RESET_PC, state=FETCH, imem_req=0 while rst=1, instr_valid=0, instr=0, instr_pc=0, addr_err=0, pending redirect cleared.
- States: FETCH, WAIT, ISSUE.
- FETCH: imem_req=1, imem_addr=pc. If imem_ack=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, go to ISSUE. Otherwise go to WAIT.
- WAIT: imem_req=1 and imem_addr stays constant until ack. On ack, perform the same capture as FETCH and go to ISSUE.
- ISSUE: imem_req=0, instr_valid=1.
  - Consume cycle is dec_ready=1 and stall=0.
  - On consume: pc<=next_pc, instr_valid<=0, go to FETCH.
  - Without consume: all outputs hold.
- Throughput: 2 cycles per instruction minimum (ack in FETCH, consume on the first ISSUE cycle).
- next_pc priority: jr > jmp > br_taken > sequential.
  - seq = instr_pc+4.
  - branch = instr_pc+4+sext32({br_imm16,2'b00}).
  - jump = {seq[31:28],jmp_idx,2'b00}.
  - jr = jr_target.
- All adds are modulo 2^32; wrap-around is silent.
- jr with jr_target[1:0]!=0: pc<=EXC_VEC, addr_err=1 for exactly that cycle.
- Redirect inputs are ignored outside consume cycles.
- imem_ack while imem_req=0 has no effect.
- Async reset mid-fetch abandons the outstanding request. The first cycle after reset release re-requests RESET_PC.

Optional Feature:
PC_FETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot): a redirect in a consume cycle is stored as a pending target and pc<=instr_pc+4. On the next consume (the slot instruction), pc<=pending target and pending is cleared. Redirect inputs presented with the slot instruction are ignored. A misaligned jr raises addr_err when it is captured; EXC_VEC becomes the pending target.
- Undefined: redirects take effect immediately, as in the base behaviour, and no pending register exists.

Test Plan:
- Reset with imem_ack tied 1 and dec_ready=1 -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008. One instruction issues every 2 cycles.
- imem_ack delayed 3 cycles -> imem_req high and imem_addr constant for 4 cycles. instr_valid rises the cycle after ack.
- instr_pc=0x00400010, br_taken=1, br_imm16=16'hFFFC -> next imem_addr=0x00400004. With br_imm16=16'h0003 -> next imem_addr=0x00400020.
- instr_pc=0x00400000, jmp=1, jmp_idx=26'h0100010, br_taken=1 simultaneously -> next imem_addr=0x00400040 (jump wins). jr=1 with jr_target=0x00400102 -> addr_err pulse, next imem_addr=0x00400004.
- stall=1 for 5 cycles in ISSUE -> instr and instr_pc unchanged, no imem_req. instr_pc=0xFFFFFFFC consumed with no redirect -> next imem_addr=0x00000000.
- Async rst asserted during WAIT -> imem_req drops immediately and pc=0x00400000. With PC_FETCH_DELAY_SLOT_EN: a branch at 0x00400010 to 0x00400040 produces fetch addresses 0x00400014, then 0x00400040.
